sync_iter_multiplier: RTL and testbench

- Parametrised, multi-cycle signed/unsigned integer multiplier with valid/ready handshakes on its input and output.
- Successor to the single-width synchronous multiplier wrapper. It replaces the derived slow clock with a single-clock iterative datapath that retires STEP multiplier bits per cycle.
- Operand width, per-cycle throughput and signedness (per operation) are configurable.
- Sits between register-file/ALU operand staging and writeback in the arithmetic test harnesses.

---
 rtl/sync_iter_multiplier.sv | 187 ++++++++++++++++++
 tb/tb_sync_iter_multiplier.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_iter_multiplier.sv
// sync_iter_multiplier
//
// Multi-cycle integer multiplier. It works on one clock and retires STEP
// multiplier bits per cycle. Operands are taken as magnitudes plus a sign
// flag, the magnitudes are multiplied by shift-and-add, and the sign is
// applied on the final CALC cycle. Each operation selects signed or
// unsigned operands on its own.
//
// Timeline for an operation accepted at edge T:
//   edges T+1 .. T+ITER : one partial product per edge is added into acc
//   edge  T+ITER+1      : sign applied, c loaded, out_valid rises
//
// Parameters:
//   WIDTH  operand width; the product is 2*WIDTH bits
//   STEP   multiplier bits per CALC cycle (1, 2, 4 or 8; must divide WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   a, b and is_signed are valid
//   in_ready   the block can accept an operation (IDLE only)
//   a          multiplicand
//   b          multiplier
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  c holds a finished product
//   out_ready  the consumer accepts c
//   c          product, held until the next result or reset
//   busy       high in CALC or DONE

module sync_iter_multiplier #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] c,
    output logic               busy
);

    localparam int ITER  = WIDTH / STEP;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam int SH_W  = $clog2(2 * WIDTH) + 1;
    localparam int PP_W  = WIDTH + STEP;

    // Reject unsupported configurations at elaboration. The module name
    // below does not exist, so elaboration fails.
    generate
        if (!((STEP == 1) || (STEP == 2) || (STEP == 4) || (STEP == 8)) ||
            ((WIDTH % STEP) != 0)) begin : g_illegal_params
            sync_iter_multiplier_illegal_step_or_width u_illegal_params ();
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [WIDTH-1:0]     mag_a_q,     mag_a_d;
    logic [WIDTH-1:0]     mag_b_q,     mag_b_d;
    logic [2*WIDTH-1:0]   acc_q,       acc_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic                 neg_q,       neg_d;
    logic [2*WIDTH-1:0]   c_q,         c_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;

    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [PP_W-1:0]      pp;
    logic [SH_W-1:0]      shift_amt;
    logic [2*WIDTH-1:0]   pp_shifted;

    // Operand magnitudes. Negating the most negative value gives back
    // the same bit pattern, and that pattern is the correct unsigned
    // magnitude 2^(WIDTH-1).
    always_comb begin
        abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b = (is_signed && b[WIDTH-1]) ? -b : b;
    end

    // Partial product: the low STEP multiplier bits times the multiplicand,
    // moved up to the weight of the bits retired so far.
    always_comb begin
        pp         = PP_W'(mag_b_q[STEP-1:0]) * PP_W'(mag_a_q);
        shift_amt  = SH_W'(cnt_q) * SH_W'(STEP);
        pp_shifted = (2*WIDTH)'(pp) << shift_amt;
    end

    // Next-state logic. CALC runs ITER accumulate cycles and then one more
    // cycle that applies the sign and loads c. out_valid is therefore high
    // on the same cycles the state is DONE.
    always_comb begin
        state_d     = state_q;
        mag_a_d     = mag_a_q;
        mag_b_d     = mag_b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        c_d         = c_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mag_a_d = abs_a;
                    mag_b_d = abs_b;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end

            CALC: begin
                if (cnt_q == CNT_W'(ITER)) begin
                    c_d         = neg_q ? -acc_q : acc_q;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d   = acc_q + pp_shifted;
                    mag_b_d = mag_b_q >> STEP;
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset clears everything and drops any
    // operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            c_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_a_q     <= mag_a_d;
            mag_b_q     <= mag_b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // in_ready stays low while reset is held, so nothing is accepted
    // during reset.
    assign in_ready  = rst & (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sync_iter_multiplier.sv
// tb_sync_iter_multiplier
//
// Bench for sync_iter_multiplier. It drives two instances:
//   dut0: WIDTH=32, STEP=1
//   dut1: WIDTH=16, STEP=4
// A behavioural model predicts the handshake outputs and the product from
// plain arithmetic. A compare process checks each DUT against its model on
// every falling edge. Directed tasks also check literal products and
// latencies.

module tb_sync_iter_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid0 = 1'b0, out_ready0 = 1'b1, is_signed0 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0;
    logic        in_ready0, out_valid0, busy0;
    logic [63:0] c0;

    logic        in_valid1 = 1'b0, out_ready1 = 1'b1, is_signed1 = 1'b0;
    logic [15:0] a1 = '0, b1 = '0;
    logic        in_ready1, out_valid1, busy1;
    logic [31:0] c1;

    int tests_run    = 0;
    int tests_failed = 0;
    int hs0          = 0;

    sync_iter_multiplier #(.WIDTH(32), .STEP(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .is_signed(is_signed0), .out_valid(out_valid0),
        .out_ready(out_ready0), .c(c0), .busy(busy0)
    );

    sync_iter_multiplier #(.WIDTH(16), .STEP(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .is_signed(is_signed1), .out_valid(out_valid1),
        .out_ready(out_ready1), .c(c1), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Model phases: 0 = accepting, 1 = computing, 2 = result valid.
    typedef struct {
        int          phase;
        int          cycles;
        logic [63:0] pending;
        logic [63:0] c;
    } model_t;

    model_t m0, m1;

    // Reference product from ordinary integer arithmetic. The operands are
    // extended to 64 bits and the result is masked to 2*w bits.
    function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b,
                                               input logic s, input int w);
        logic [63:0] ea, eb, mask, p;
        ea = 64'(a) & ((64'd1 << w) - 64'd1);
        eb = 64'(b) & ((64'd1 << w) - 64'd1);
        if (s && ea[w-1]) ea = ea | (~64'd0 << w);
        if (s && eb[w-1]) eb = eb | (~64'd0 << w);
        p    = ea * eb;
        mask = (w == 32) ? ~64'd0 : ((64'd1 << (2*w)) - 64'd1);
        return p & mask;
    endfunction

    // An accepted operation becomes visible iter+1 cycles later and stays
    // until it is taken.
    function automatic model_t nextModel(input model_t m, input logic iv, input logic ordy,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic s, input int w, input int iter);
        model_t n;
        n = m;
        case (m.phase)
            0: if (iv) begin
                   n.phase   = 1;
                   n.cycles  = 0;
                   n.pending = refProduct(a, b, s, w);
               end
            1: begin
                   n.cycles = m.cycles + 1;
                   if (n.cycles == iter + 1) begin
                       n.phase = 2;
                       n.c     = m.pending;
                   end
               end
            default: if (ordy) n.phase = 0;
        endcase
        return n;
    endfunction

    function automatic model_t resetModel();
        model_t r;
        r.phase   = 0;
        r.cycles  = 0;
        r.pending = '0;
        r.c       = '0;
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0 <= resetModel();
            m1 <= resetModel();
        end else begin
            m0 <= nextModel(m0, in_valid0, out_ready0, a0, b0, is_signed0, 32, 32);
            m1 <= nextModel(m1, in_valid1, out_ready1, 32'(a1), 32'(b1), is_signed1, 16, 4);
        end
    end

    always @(posedge clk) begin
        if (rst && out_valid0 && out_ready0) hs0 <= hs0 + 1;
    end

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every-cycle comparison of both DUTs against their models.
    always @(negedge clk) begin
        if (rst) begin
            checkVal("dut0 in_ready",  64'(in_ready0),  64'(m0.phase == 0));
            checkVal("dut0 out_valid", 64'(out_valid0), 64'(m0.phase == 2));
            checkVal("dut0 busy",      64'(busy0),      64'(m0.phase != 0));
            if (m0.phase == 2) checkVal("dut0 c", c0, m0.c);
            checkVal("dut1 in_ready",  64'(in_ready1),  64'(m1.phase == 0));
            checkVal("dut1 out_valid", 64'(out_valid1), 64'(m1.phase == 2));
            checkVal("dut1 busy",      64'(busy1),      64'(m1.phase != 0));
            if (m1.phase == 2) checkVal("dut1 c", 64'(c1), m1.c);
        end
    end

    // Presents one operation and returns just after the edge that accepts it.
    task automatic applyStimulus(input int sel, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
        @(negedge clk);
        if (sel == 0) begin
            a0 = a; b0 = b; is_signed0 = s; in_valid0 = 1'b1;
        end else begin
            a1 = a[15:0]; b1 = b[15:0]; is_signed1 = s; in_valid1 = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    // Waits for out_valid with a cycle bound. It then checks the latency and
    // the literal product. If handshake is set, it also checks the return
    // to IDLE after the handshake edge.
    task automatic checkOutput(input int sel, input string name, input logic [63:0] exp,
                               input int expLat, input bit handshake);
        int k;
        logic ov;
        k  = 0;
        ov = 1'b0;
        while (!ov && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            ov = (sel == 0) ? out_valid0 : out_valid1;
        end
        if (!ov) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s timeout: got no out_valid expected one within 200 cycles", name);
            return;
        end
        checkVal({name, " latency"}, 64'(k), 64'(expLat));
        checkVal({name, " product"}, (sel == 0) ? c0 : 64'(c1), exp);
        if (handshake) begin
            @(posedge clk);
            #1;
            checkVal({name, " out_valid after handshake"},
                     64'((sel == 0) ? out_valid0 : out_valid1), 64'd0);
            checkVal({name, " in_ready after handshake"},
                     64'((sel == 0) ? in_ready0 : in_ready1), 64'd1);
        end
    endtask

    initial begin
        int hsBefore;

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        #1;
        checkVal("reset out_valid", 64'(out_valid0), 64'd0);
        checkVal("reset busy",      64'(busy0),      64'd0);
        checkVal("reset c",         c0,              64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("in_ready after reset", 64'(in_ready0), 64'd1);

        applyStimulus(0, 32'd3, -32'sd5, 1'b1);
        checkOutput(0, "3x-5", 64'hFFFF_FFFF_FFFF_FFF1, 33, 1);

        applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkOutput(0, "umax sq", 64'hFFFF_FFFE_0000_0001, 33, 1);

        applyStimulus(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        checkOutput(0, "-1x-1", 64'h0000_0000_0000_0001, 33, 1);

        applyStimulus(0, 32'h8000_0000, 32'h8000_0000, 1'b1);
        checkOutput(0, "smin sq", 64'h4000_0000_0000_0000, 33, 1);

        applyStimulus(0, 32'h8000_0000, 32'd1, 1'b1);
        checkOutput(0, "smin x1", 64'hFFFF_FFFF_8000_0000, 33, 1);

        applyStimulus(0, 32'd0, -32'sd7, 1'b1);
        checkOutput(0, "0x-7", 64'd0, 33, 1);

        applyStimulus(1, 32'(16'hFB2E), 32'(16'h0237), 1'b1);
        checkOutput(1, "w16 -1234x567", 64'h0000_0000_FFF5_52E2, 5, 1);

        applyStimulus(1, 32'(16'hFFFF), 32'(16'hFFFF), 1'b0);
        checkOutput(1, "w16 umax sq", 64'h0000_0000_FFFE_0001, 5, 1);

        // Backpressure: the result must stay put while in_valid pulses are
        // ignored.
        out_ready0 = 1'b0;
        applyStimulus(0, 32'd1000, 32'd3000, 1'b0);
        checkOutput(0, "bp", 64'd3000000, 33, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid0 = i[0];
            a0 = $urandom;
            b0 = $urandom;
            @(posedge clk);
            #1;
            checkVal("bp hold c",         c0,               64'd3000000);
            checkVal("bp hold out_valid", 64'(out_valid0),  64'd1);
            checkVal("bp hold in_ready",  64'(in_ready0),   64'd0);
        end
        @(negedge clk);
        in_valid0 = 1'b0;
        hsBefore = hs0;
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        checkVal("bp release out_valid", 64'(out_valid0), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        checkVal("bp handshake count", 64'(hs0 - hsBefore), 64'd1);

        // Reset in the middle of CALC drops the operation.
        applyStimulus(0, 32'd100, 32'd200, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkVal("midreset out_valid", 64'(out_valid0), 64'd0);
        checkVal("midreset busy",      64'(busy0),      64'd0);
        checkVal("midreset c",         c0,              64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        applyStimulus(0, 32'd7, 32'd6, 1'b0);
        checkOutput(0, "7x6 after reset", 64'd42, 33, 1);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
